// File: rtl/spi_bridge_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : spi_bridge_pkg
// Desc   : Shared types and constants for the SPI-to-register bridge.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
package spi_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    ADDR  = 3'd2,
    DATA  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  localparam logic [7:0] CMD_WRITE = 8'h80;
  localparam logic [7:0] CMD_READ  = 8'h00;

  // PWM controller register map
  localparam logic [7:0] ADDR_CTL0    = 8'h00;
  localparam logic [7:0] ADDR_DUTY_HI = 8'h01;
  localparam logic [7:0] ADDR_DUTY_LO = 8'h10;

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : spi_sync_edge
// Desc   : Multi-stage synchronizer with rise/fall pulses on the synced level.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk_i,
  input  logic nrst_i,
  input  logic din_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], din_i};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign level_o = r_sync[SYNC_STAGES-1];
  assign rise_o  = level_o & ~r_prev;
  assign fall_o  = ~level_o & r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_reg_bridge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : spi_reg_bridge
// Desc   : SPI mode-0 slave turning CMD/ADDR/DATA frames into register bus
//          cycles. Define AUTO_INC_EN for address auto-increment bursts.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module spi_reg_bridge
  import spi_bridge_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       nrst_i,
  input  logic       spi_sclk_i,
  input  logic       spi_ncs_i,
  input  logic       spi_mosi_i,
  output logic       spi_miso_o,
  output logic       spi_miso_oe_o,
  output logic [7:0] b_addr_o,
  output logic [7:0] b_data_o,
  output logic       b_write_o,
  input  logic [7:0] b_data_i,
  output logic       frame_err_o
);

  logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
  logic w_ncs, w_ncs_rise, w_ncs_fall;
  logic w_unused_sclk;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic w_mosi;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk_i(clk_i), .nrst_i(nrst_i), .din_i(spi_sclk_i),
    .level_o(w_sclk_lvl), .rise_o(w_sclk_rise), .fall_o(w_sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ncs_sync (
    .clk_i(clk_i), .nrst_i(nrst_i), .din_i(spi_ncs_i),
    .level_o(w_ncs), .rise_o(w_ncs_rise), .fall_o(w_ncs_fall)
  );

  assign w_unused_sclk = w_sclk_lvl;

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) r_mosi_sync <= '0;
    else         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
  end
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

  state_t     r_state, w_state_n;
  logic [2:0] r_cnt, w_cnt_n;
  logic [7:0] r_rx, w_rx_n, w_byte;
  logic [7:0] r_tx;
  logic [7:0] r_addr, w_addr_n, r_data, w_data_n;
  logic       r_is_read, w_is_read_n;
  logic       r_data_done, w_data_done_n;
  logic       r_load, w_load_n;
  logic       r_write, w_write_n;
  logic       r_err, w_err_n;

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      r_state     <= IDLE;
      r_cnt       <= 3'd0;
      r_rx        <= 8'd0;
      r_addr      <= 8'd0;
      r_data      <= 8'd0;
      r_is_read   <= 1'b0;
      r_data_done <= 1'b0;
      r_load      <= 1'b0;
      r_write     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_cnt       <= w_cnt_n;
      r_rx        <= w_rx_n;
      r_addr      <= w_addr_n;
      r_data      <= w_data_n;
      r_is_read   <= w_is_read_n;
      r_data_done <= w_data_done_n;
      r_load      <= w_load_n;
      r_write     <= w_write_n;
      r_err       <= w_err_n;
    end
  end

  always_comb begin
    w_state_n     = r_state;
    w_cnt_n       = r_cnt;
    w_rx_n        = r_rx;
    w_addr_n      = r_addr;
    w_data_n      = r_data;
    w_is_read_n   = r_is_read;
    w_data_done_n = r_data_done;
    w_load_n      = 1'b0;
    w_write_n     = 1'b0;
    w_err_n       = 1'b0;
    w_byte        = {r_rx[6:0], w_mosi};

    if (r_state == IDLE) begin
      w_cnt_n       = 3'd0;
      w_data_done_n = 1'b0;
      if (w_ncs_fall) w_state_n = CMD;
    end else if (w_sclk_rise) begin
      w_rx_n  = w_byte;
      w_cnt_n = r_cnt + 3'd1;
      if (r_cnt == 3'd7) begin
        case (r_state)
          CMD: begin
            if (w_byte == CMD_WRITE) begin
              w_is_read_n = 1'b0;
              w_state_n   = ADDR;
            end else if (w_byte == CMD_READ) begin
              w_is_read_n = 1'b1;
              w_state_n   = ADDR;
            end else begin
              w_err_n   = 1'b1;
              w_state_n = DRAIN;
            end
          end
          ADDR: begin
            w_addr_n  = w_byte;
            w_load_n  = r_is_read;
            w_state_n = DATA;
          end
          DATA: begin
            w_data_done_n = 1'b1;
            if (!r_is_read) begin
              w_data_n  = w_byte;
              w_write_n = 1'b1;
            end
`ifdef AUTO_INC_EN
            // reads advance after each byte; writes advance before each byte after the first
            if (r_is_read) begin
              w_addr_n = r_addr + 8'd1;
              w_load_n = 1'b1;
            end else if (r_data_done) begin
              w_addr_n = r_addr + 8'd1;
            end
`else
            w_state_n = DRAIN;
`endif
          end
          default: ;
        endcase
      end
    end

    // The sclk edge above is folded in first, so a final edge coinciding with ncs rise still counts
    if (r_state != IDLE && w_ncs_rise) begin
      if ((w_state_n == CMD && w_cnt_n != 3'd0) || w_state_n == ADDR ||
          (w_state_n == DATA && !w_data_done_n))
        w_err_n = 1'b1;
      w_state_n = IDLE;
    end
  end

  // Load lands one cycle after the address update so b_data_i reflects the new address
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i)
      r_tx <= 8'd0;
    else if (r_load)
      r_tx <= b_data_i;
    else if (w_sclk_fall && r_state == DATA && r_cnt != 3'd0)
      r_tx <= {r_tx[6:0], 1'b0};
  end

  assign spi_miso_o    = (r_state == DATA && r_is_read) ? r_tx[7] : 1'b0;
  assign spi_miso_oe_o = ~w_ncs;
  assign b_addr_o      = r_addr;
  assign b_data_o      = r_data;
  assign b_write_o     = r_write;
  assign frame_err_o   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_bridge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_spi_reg_bridge
// Desc   : Randomized self-checking bench for spi_reg_bridge with a frame-level model.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_spi_reg_bridge;

  localparam int HALF = 8;

  logic       clk_i = 1'b0;
  logic       nrst_i = 1'b0;
  logic       spi_sclk_i = 1'b0;
  logic       spi_ncs_i = 1'b1;
  logic       spi_mosi_i = 1'b0;
  logic       spi_miso_o, spi_miso_oe_o, b_write_o, frame_err_o;
  logic [7:0] b_addr_o, b_data_o, b_data_i;

  logic [7:0] rom [0:255];
  logic [7:0] fb  [0:5];
  logic [7:0] mb  [0:5];
  logic [7:0] wr_a[$];
  logic [7:0] wr_d[$];
  int         err_seen;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_addr = 8'd0;
  logic [7:0] exp_data = 8'd0;

  always #5 clk_i = ~clk_i;

  assign b_data_i = rom[b_addr_o];

  spi_reg_bridge #(.SYNC_STAGES(2)) dut (
    .clk_i(clk_i), .nrst_i(nrst_i),
    .spi_sclk_i(spi_sclk_i), .spi_ncs_i(spi_ncs_i), .spi_mosi_i(spi_mosi_i),
    .spi_miso_o(spi_miso_o), .spi_miso_oe_o(spi_miso_oe_o),
    .b_addr_o(b_addr_o), .b_data_o(b_data_o), .b_write_o(b_write_o),
    .b_data_i(b_data_i), .frame_err_o(frame_err_o)
  );

  always @(negedge clk_i) begin
    if (b_write_o) begin
      wr_a.push_back(b_addr_o);
      wr_d.push_back(b_data_o);
    end
    if (frame_err_o) err_seen++;
  end

  task automatic spi_bits(input int nbits);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi_i = fb[i/8][7 - (i%8)];
      repeat (HALF) @(negedge clk_i);
      spi_sclk_i = 1'b1;
      mb[i/8][7 - (i%8)] = spi_miso_o;
      repeat (HALF) @(negedge clk_i);
      spi_sclk_i = 1'b0;
    end
  endtask

  task automatic run_frame(input string name, input int nbits);
    int         nfull;
    bit         valid, is_rd;
    int         exp_err;
    logic [7:0] ea[$];
    logic [7:0] ed[$];
    logic [7:0] em, ai;

    nfull   = nbits / 8;
    valid   = (nfull >= 1) && (fb[0] == 8'h80 || fb[0] == 8'h00);
    is_rd   = (fb[0] == 8'h00);
    exp_err = 0;
    if (nbits > 0 && !valid) exp_err = 1;
    else if (valid && nfull < 3) exp_err = 1;
    if (valid && !is_rd && nfull >= 3) begin
      ea.push_back(fb[1]);
      ed.push_back(fb[2]);
`ifdef AUTO_INC_EN
      for (int k = 3; k < nfull; k++) begin
        ai = fb[1] + 8'(k - 2);
        ea.push_back(ai);
        ed.push_back(fb[k]);
      end
`endif
    end
    if (valid && nfull >= 2) begin
      exp_addr = fb[1];
`ifdef AUTO_INC_EN
      if (!is_rd && nfull >= 4) exp_addr = fb[1] + 8'(nfull - 3);
      if (is_rd && nfull >= 3)  exp_addr = fb[1] + 8'(nfull - 2);
`endif
    end
    if (ed.size() > 0) exp_data = ed[ed.size()-1];

    wr_a.delete();
    wr_d.delete();
    err_seen = 0;
    for (int k = 0; k < 6; k++) mb[k] = 8'h00;

    @(negedge clk_i);
    spi_ncs_i = 1'b0;
    repeat (HALF) @(negedge clk_i);
    checks++;
    if (spi_miso_oe_o !== 1'b1) begin
      errors++;
      $display("FAIL %s oe_active: got %b expected 1", name, spi_miso_oe_o);
    end
    spi_bits(nbits);
    repeat (HALF) @(negedge clk_i);
    spi_ncs_i = 1'b1;
    repeat (12) @(negedge clk_i);

    checks++;
    if (wr_a.size() !== ea.size()) begin
      errors++;
      $display("FAIL %s write_count: got %0d expected %0d", name, wr_a.size(), ea.size());
    end
    for (int k = 0; k < ea.size() && k < wr_a.size(); k++) begin
      checks++;
      if (wr_a[k] !== ea[k] || wr_d[k] !== ed[k]) begin
        errors++;
        $display("FAIL %s write%0d: got %h/%h expected %h/%h", name, k, wr_a[k], wr_d[k], ea[k], ed[k]);
      end
    end
    checks++;
    if (err_seen !== exp_err) begin
      errors++;
      $display("FAIL %s frame_err: got %0d pulses expected %0d", name, err_seen, exp_err);
    end
    checks++;
    if (b_addr_o !== exp_addr || b_data_o !== exp_data) begin
      errors++;
      $display("FAIL %s bus_regs: got %h/%h expected %h/%h", name, b_addr_o, b_data_o, exp_addr, exp_data);
    end
    for (int k = 0; k < nfull; k++) begin
      em = 8'h00;
      if (valid && is_rd && k == 2) em = rom[fb[1]];
`ifdef AUTO_INC_EN
      if (valid && is_rd && k >= 2) begin
        ai = fb[1] + 8'(k - 2);
        em = rom[ai];
      end
`endif
      checks++;
      if (mb[k] !== em) begin
        errors++;
        $display("FAIL %s miso_byte%0d: got %h expected %h", name, k, mb[k], em);
      end
    end
    checks++;
    if (spi_miso_oe_o !== 1'b0 || spi_miso_o !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_miso: got oe=%b miso=%b expected 0/0", name, spi_miso_oe_o, spi_miso_o);
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if ({b_addr_o, b_data_o, b_write_o, frame_err_o, spi_miso_o, spi_miso_oe_o} !== 20'd0) begin
      errors++;
      $display("FAIL %s reset_outputs: got addr=%h data=%h wr=%b err=%b miso=%b oe=%b expected all 0",
               name, b_addr_o, b_data_o, b_write_o, frame_err_o, spi_miso_o, spi_miso_oe_o);
    end
  endtask

  task automatic test_reset();
    nrst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check_reset_values("reset");
    nrst_i = 1'b1;
    repeat (4) @(negedge clk_i);
    check_reset_values("post_reset");
  endtask

  task automatic test_write();
    fb[0] = 8'h80; fb[1] = 8'h00; fb[2] = 8'h81;
    run_frame("write_00_81", 24);
    fb[0] = 8'h80; fb[1] = 8'h01; fb[2] = 8'h03;
    run_frame("write_01_03", 24);
    fb[0] = 8'h80; fb[1] = 8'h10; fb[2] = 8'hFF;
    run_frame("write_10_FF", 24);
  endtask

  task automatic test_read();
    fb[0] = 8'h00; fb[1] = 8'h10; fb[2] = 8'h5C;
    run_frame("read_10", 24);
  endtask

  task automatic test_bad_cmd();
    fb[0] = 8'h42; fb[1] = 8'h01; fb[2] = 8'h77;
    run_frame("bad_cmd", 24);
  endtask

  task automatic test_abort();
    fb[0] = 8'h80; fb[1] = 8'h01; fb[2] = 8'hF0;
    run_frame("abort_data", 20);
    run_frame("empty_frame", 0);
    fb[0] = 8'h80;
    run_frame("abort_cmd", 5);
  endtask

  task automatic test_auto_inc();
    fb[0] = 8'h80; fb[1] = 8'hFF; fb[2] = 8'h11; fb[3] = 8'h22;
    run_frame("burst_wrap", 32);
    fb[0] = 8'h00; fb[1] = 8'h3E; fb[2] = 8'h00; fb[3] = 8'h00; fb[4] = 8'h00;
    run_frame("burst_read", 40);
  endtask

  task automatic test_reset_midframe();
    fb[0] = 8'h80; fb[1] = 8'h5A; fb[2] = 8'h6B;
    wr_a.delete();
    err_seen = 0;
    @(negedge clk_i);
    spi_ncs_i = 1'b0;
    repeat (HALF) @(negedge clk_i);
    spi_bits(20);
    nrst_i = 1'b0;
    #1;
    check_reset_values("midframe_reset");
    spi_ncs_i = 1'b1;
    repeat (6) @(negedge clk_i);
    nrst_i = 1'b1;
    exp_addr = 8'd0;
    exp_data = 8'd0;
    repeat (8) @(negedge clk_i);
    checks++;
    if (wr_a.size() !== 0 || err_seen !== 0) begin
      errors++;
      $display("FAIL midframe_quiet: got %0d writes %0d errs expected 0/0", wr_a.size(), err_seen);
    end
    fb[0] = 8'h80; fb[1] = 8'h01; fb[2] = 8'h9D;
    run_frame("after_reset", 24);
  endtask

  task automatic test_random();
    int r;
    for (int n = 0; n < 24; n++) begin
      r = $urandom_range(0, 3);
      for (int k = 0; k < 6; k++) fb[k] = 8'($urandom);
      if (r == 0 || r == 3) fb[0] = 8'h80;
      else if (r == 1)      fb[0] = 8'h00;
      run_frame("random", $urandom_range(0, 48));
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) rom[a] = 8'($urandom);
    rom[8'h10] = 8'hA5;
    test_reset();
    test_write();
    test_read();
    test_bad_cmd();
    test_abort();
    test_auto_inc();
    test_reset_midframe();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
